bayer_window_buffer: RTL and testbench
======================================

BAYER_WINDOW_BUFFER -- requirements
Module: bayer_window_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 640: active pixels per line, at least 3.
REQ-002 SHALL have parameter HEIGHT, default 480: active lines per frame, at least 3.
REQ-003 SHALL have parameter BIT_WIDTH, default 8: bits per raw Bayer sample.
REQ-004 SHALL have parameter FIRST_PIXEL_TYPE, default 2'b00: Bayer type of pixel (0,0).
REQ-005 SHALL have port clk_pixel, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port pixel_in, input, BIT_WIDTH bits: raw sample, raster order.
REQ-008 SHALL have port pixel_in_valid, input, 1 bit: pixel_in is valid this cycle.
REQ-009 SHALL have port pixel_in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-010 SHALL have port pixel_matrix, output, [BIT_WIDTH-1:0] [0:4][0:4]: 5x5 window, [row][col], centre at [2][2].
REQ-011 SHALL have port pixel_enable_matrix, output, 1 bit [0:4][0:4]: per-entry validity.
REQ-012 SHALL have port center_pixel_type, output, 2 bits: Bayer type of the centre pixel.
REQ-013 SHALL have port center_x, output, $clog2(WIDTH) bits: centre column.
REQ-014 SHALL have port center_y, output, $clog2(HEIGHT) bits: centre row.
REQ-015 SHALL have port window_valid, output, 1 bit: one-cycle strobe marking a new window on all window outputs.

Function
REQ-016 SHALL accept a sample only when pixel_in_valid and pixel_in_ready are both high; sample k (0-based) of a frame is pixel (k mod WIDTH, k div WIDTH).
REQ-017 SHALL implement the states FILL (k < 2*WIDTH+2), RUN, and FLUSH.
REQ-018 SHALL move FILL->RUN on acceptance of sample 2*WIDTH+2, RUN->FLUSH on acceptance of sample WIDTH*HEIGHT-1, and FLUSH->FILL after its last flush step.
REQ-019 SHALL drive pixel_in_ready high in FILL and RUN, and low in FLUSH and during reset.
REQ-020 SHALL, in RUN and on the FILL->RUN acceptance, assert window_valid on the cycle after accepting sample k, with centre at linear index k-(2*WIDTH+2).
REQ-021 SHALL, in FLUSH, emit exactly one window per cycle for exactly 2*WIDTH+2 consecutive cycles, with centres continuing in raster order up to (WIDTH-1,HEIGHT-1).
REQ-022 SHALL not emit a window on cycles where no sample is accepted outside FLUSH; input gaps SHALL not alter window contents or ordering.
REQ-023 SHALL set pixel_matrix[r][c] to pixel (center_x+c-2, center_y+r-2) and the matching enable to 1 when that position lies inside the frame.
REQ-024 SHALL treat out-of-frame positions, including horizontal wrap into an adjacent line, according to REQ-032/REQ-033.
REQ-025 SHALL compute center_pixel_type = FIRST_PIXEL_TYPE ^ {center_y[0], center_x[0]}.
REQ-026 SHALL hold all window outputs stable while window_valid is low.
REQ-027 SHALL store lines in four WIDTH-deep line buffers plus a 5x5 register window; no frame buffer.

Reset
REQ-028 SHALL, on reset, set the state to FILL, zero all counters, set window_valid to 0, zero pixel_matrix, zero pixel_enable_matrix, set center_x/center_y to 0, set center_pixel_type to FIRST_PIXEL_TYPE, and set pixel_in_ready to 0.
REQ-029 SHALL drive pixel_in_ready to 1 on the first cycle after reset deasserts.
REQ-030 SHALL, on reset asserted mid-frame or mid-flush, abandon the frame; the next accepted sample is pixel (0,0).
REQ-031 SHALL not require line buffer contents to be cleared by reset.

Configuration
REQ-032 SHALL, with macro BAYER_WINDOW_MIRROR_EN defined, fill out-of-frame entries by even reflection (-1->1, -2->2, WIDTH->WIDTH-2, WIDTH+1->WIDTH-3; likewise for rows), preserving Bayer colour, with all enables set to 1.
REQ-033 SHALL, with BAYER_WINDOW_MIRROR_EN undefined, set out-of-frame entries to 0 with enable 0.

Verification (WIDTH=8, HEIGHT=6, FIRST_PIXEL_TYPE=2'b00, pixel value = linear index, macro undefined unless stated)
REQ-034 SHALL cover reset: assert reset for 3 cycles -> window_valid=0, all matrices 0, ready=0 during reset and 1 on the following cycle.
REQ-035 SHALL cover first window: accept samples 0..18 -> the cycle after sample 18 gives window_valid=1, centre (0,0), [2][2]=0, [2][3]=1, [3][2]=8, [4][4]=18, rows 0-1 and cols 0-1 enable 0, type 2'b00.
REQ-036 SHALL cover an interior window: centre (3,2) -> [r][c]=(r)*8+(c+1), all 25 enables 1, type 2'b01.
REQ-037 SHALL cover flush: after sample 47 -> ready low exactly 18 cycles with 18 windows, last centre (7,5) with [2][3] and rows 3-4 enable 0; then ready=1 and the next frame starts at (0,0).
REQ-038 SHALL cover input gaps and mid-frame reset: valid toggled every other cycle gives a window sequence identical to gap-free input; reset after sample 30 makes the next window appear only after 19 new samples.
REQ-039 SHALL cover mirror mode: with BAYER_WINDOW_MIRROR_EN defined, centre (0,0) -> [0][0]=18, [0][2]=16, all enables 1.

Source files
------------

// File: rtl/bayer_window_buffer.sv
// bayer_window_buffer: streaming 5x5 window generator for raw Bayer video.
// Four line buffers feed a 5x5 register window that shifts one column per
// accepted sample. After the last sample of a frame the block flushes the
// remaining 2*WIDTH+2 windows by stepping on phantom samples.
// Optional feature: define BAYER_WINDOW_MIRROR_EN to fill out-of-frame
// entries by even reflection instead of zero with enable 0.
module bayer_window_buffer #(
    parameter int         WIDTH            = 640,
    parameter int         HEIGHT           = 480,
    parameter int         BIT_WIDTH        = 8,
    parameter logic [1:0] FIRST_PIXEL_TYPE = 2'b00
) (
    input  logic                         clk_pixel,
    input  logic                         reset,
    input  logic [BIT_WIDTH-1:0]         pixel_in,
    input  logic                         pixel_in_valid,
    output logic                         pixel_in_ready,
    output logic [BIT_WIDTH-1:0]         pixel_matrix        [0:4][0:4],
    output logic                         pixel_enable_matrix [0:4][0:4],
    output logic [1:0]                   center_pixel_type,
    output logic [$clog2(WIDTH)-1:0]     center_x,
    output logic [$clog2(HEIGHT)-1:0]    center_y,
    output logic                         window_valid
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int FW = $clog2(2 * WIDTH + 2);

    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [XW-1:0] X_TWO   = XW'(2);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [YW-1:0] Y_TWO   = YW'(2);
    localparam logic [FW-1:0] F_LAST  = FW'(2 * WIDTH + 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Input-side raster position (column keeps cycling during flush so the
    // line buffers stay aligned), flush step counter and centre position.
    logic [XW-1:0] in_x_q, in_x_d;
    logic [YW-1:0] in_y_q, in_y_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic [XW-1:0] ctr_x_q, ctr_x_d;
    logic [YW-1:0] ctr_y_q, ctr_y_d;

    logic accept, flushing, step, emit;
    logic fill_done, frame_last, flush_last;

    logic [XW-1:0]        rd_addr;
    logic [BIT_WIDTH-1:0] new_pix;
    logic [BIT_WIDTH-1:0] lb_rd   [0:3];
    logic [BIT_WIDTH-1:0] col_new [0:4];
    logic [BIT_WIDTH-1:0] win_q   [0:4][0:4];
    logic [BIT_WIDTH-1:0] win_d   [0:4][0:4];
    logic                 valid_q;
    logic [1:0]           type_q;
    logic [XW-1:0]        cx_q;
    logic [YW-1:0]        cy_q;

    // State register
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (fill_done)  state_d = frame_last ? S_FLUSH : S_RUN;
            S_RUN:   if (frame_last) state_d = S_FLUSH;
            S_FLUSH: if (flush_last) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    // FSM outputs: handshake, shift step and window emission strobes
    always_comb begin
        pixel_in_ready = !reset && (state_q != S_FLUSH);
        accept         = pixel_in_valid && pixel_in_ready;
        flushing       = !reset && (state_q == S_FLUSH);
        step           = accept || flushing;
        fill_done      = accept && (in_x_q == X_TWO) && (in_y_q == Y_TWO);
        frame_last     = accept && (in_x_q == X_LAST) && (in_y_q == Y_LAST);
        flush_last     = flushing && (flush_cnt_q == F_LAST);
        emit           = (state_q == S_FILL) ? fill_done : step;
    end

    // Next values of the position counters
    always_comb begin
        in_x_d      = in_x_q;
        in_y_d      = in_y_q;
        flush_cnt_d = '0;
        ctr_x_d     = ctr_x_q;
        ctr_y_d     = ctr_y_q;
        if (flush_last) begin
            in_x_d = '0;
            in_y_d = '0;
        end else if (step) begin
            in_x_d = (in_x_q == X_LAST) ? '0 : in_x_q + 1'b1;
            if (accept && (in_x_q == X_LAST)) begin
                in_y_d = (in_y_q == Y_LAST) ? '0 : in_y_q + 1'b1;
            end
        end
        if (flushing && !flush_last) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
        if (emit) begin
            ctr_x_d = (ctr_x_q == X_LAST) ? '0 : ctr_x_q + 1'b1;
            if (ctr_x_q == X_LAST) begin
                ctr_y_d = (ctr_y_q == Y_LAST) ? '0 : ctr_y_q + 1'b1;
            end
        end
    end

    // Counter registers; reset abandons any frame in progress
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            in_x_q      <= '0;
            in_y_q      <= '0;
            flush_cnt_q <= '0;
            ctr_x_q     <= '0;
            ctr_y_q     <= '0;
        end else begin
            in_x_q      <= in_x_d;
            in_y_q      <= in_y_d;
            flush_cnt_q <= flush_cnt_d;
            ctr_x_q     <= ctr_x_d;
            ctr_y_q     <= ctr_y_d;
        end
    end

    // Prefetch the column the next step will use, so the registered RAM
    // read is already valid when that sample arrives.
    assign rd_addr = reset ? '0 : in_x_d;
    assign new_pix = flushing ? '0 : pixel_in;

    // Cascaded line buffers: line gi holds the row gi+1 above the input row
    for (genvar gi = 0; gi < 4; gi++) begin : g_line
        logic [BIT_WIDTH-1:0] mem [0:WIDTH-1];
        logic [BIT_WIDTH-1:0] rd_q;
        logic [BIT_WIDTH-1:0] wr_data;

        if (gi == 0) begin : g_head
            assign wr_data = new_pix;
        end else begin : g_tail
            assign wr_data = lb_rd[gi-1];
        end

        // Write the incoming column entry, read the next column ahead
        always_ff @(posedge clk_pixel) begin
            if (step) begin
                mem[in_x_q] <= wr_data;
            end
            rd_q <= mem[rd_addr];
        end

        assign lb_rd[gi] = rd_q;
    end

    // Next window contents: shift left and insert the new column
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            col_new[r] = lb_rd[3-r];
        end
        col_new[4] = new_pix;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                win_d[r][c] = win_q[r][c];
            end
        end
        if (step) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][4] = col_new[r];
            end
        end
    end

    // Raw window register; columns wrapped from another line are never
    // exposed because those positions are out of frame
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            win_q <= win_d;
        end
    end

    // Per-entry boundary handling and output registers
    for (genvar gi = 0; gi < 5; gi++) begin : g_row
        for (genvar gj = 0; gj < 5; gj++) begin : g_col
            logic [BIT_WIDTH-1:0] ent_val;
            logic                 ent_en;
            logic [BIT_WIDTH-1:0] pix_q;
            logic                 en_q;

`ifdef BAYER_WINDOW_MIRROR_EN
            // Reflect the position back into the frame and pick that entry
            always_comb begin
                int yy;
                int xx;
                yy = int'(ctr_y_q) + gi - 2;
                xx = int'(ctr_x_q) + gj - 2;
                if (yy < 0) begin
                    yy = -yy;
                end else if (yy >= HEIGHT) begin
                    yy = 2 * HEIGHT - 2 - yy;
                end
                if (xx < 0) begin
                    xx = -xx;
                end else if (xx >= WIDTH) begin
                    xx = 2 * WIDTH - 2 - xx;
                end
                ent_val = win_d[3'(yy - int'(ctr_y_q) + 2)][3'(xx - int'(ctr_x_q) + 2)];
                ent_en  = 1'b1;
            end
`else
            // Zero the entry and clear its enable when outside the frame
            always_comb begin
                int   yy;
                int   xx;
                logic in_frame;
                yy = int'(ctr_y_q) + gi - 2;
                xx = int'(ctr_x_q) + gj - 2;
                in_frame = (yy >= 0) && (yy < HEIGHT) && (xx >= 0) && (xx < WIDTH);
                ent_val  = in_frame ? win_d[gi][gj] : '0;
                ent_en   = in_frame;
            end
`endif

            // Capture the entry only when a window is emitted
            always_ff @(posedge clk_pixel) begin
                if (reset) begin
                    pix_q <= '0;
                    en_q  <= 1'b0;
                end else if (emit) begin
                    pix_q <= ent_val;
                    en_q  <= ent_en;
                end
            end

            assign pixel_matrix[gi][gj]        = pix_q;
            assign pixel_enable_matrix[gi][gj] = en_q;
        end
    end

    // Window strobe and centre descriptors, held between windows
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            valid_q <= 1'b0;
            type_q  <= FIRST_PIXEL_TYPE;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            valid_q <= emit;
            if (emit) begin
                type_q <= FIRST_PIXEL_TYPE ^ {ctr_y_q[0], ctr_x_q[0]};
                cx_q   <= ctr_x_q;
                cy_q   <= ctr_y_q;
            end
        end
    end

    assign window_valid      = valid_q;
    assign center_pixel_type = type_q;
    assign center_x          = cx_q;
    assign center_y          = cy_q;

endmodule

// File: tb/tb_bayer_window_buffer.sv
// Scoreboard bench for bayer_window_buffer (8x6 frame, pixel = linear index).
// Stimulus pushes the expected window centre on each accepted sample; the
// monitor pops and compares every emitted window against a coordinate model.
module tb_bayer_window_buffer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int NF = 2 * W + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pix;
    logic       valid;
    logic       ready;
    logic [7:0] mat [0:4][0:4];
    logic       en  [0:4][0:4];
    logic [1:0] ptype;
    logic [2:0] cx;
    logic [2:0] cy;
    logic       wv;

    always #5 clk = ~clk;

    bayer_window_buffer #(
        .WIDTH(W), .HEIGHT(H), .BIT_WIDTH(8), .FIRST_PIXEL_TYPE(2'b00)
    ) dut (
        .clk_pixel(clk), .reset(reset), .pixel_in(pix), .pixel_in_valid(valid),
        .pixel_in_ready(ready), .pixel_matrix(mat), .pixel_enable_matrix(en),
        .center_pixel_type(ptype), .center_x(cx), .center_y(cy), .window_valid(wv)
    );

    typedef struct { int x; int y; } ctr_t;
    ctr_t exp_q[$];

    int chk_total = 0;
    int chk_pass  = 0;
    int k_bench   = 0;
    int win_seen  = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        chk_total++;
        if (ok) chk_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected value/enable of window entry [r][c] for centre (ex,ey)
    function automatic void exp_entry(input int ex, input int ey, input int r, input int c,
                                      output int val, output int ena);
        int x;
        int y;
        x = ex + c - 2;
        y = ey + r - 2;
`ifdef BAYER_WINDOW_MIRROR_EN
        if (x < 0) x = -x;
        if (x >= W) x = 2 * W - 2 - x;
        if (y < 0) y = -y;
        if (y >= H) y = 2 * H - 2 - y;
        val = y * W + x;
        ena = 1;
`else
        if (x >= 0 && x < W && y >= 0 && y < H) begin
            val = y * W + x;
            ena = 1;
        end else begin
            val = 0;
            ena = 0;
        end
`endif
    endfunction

    function automatic void push_ctr(input int idx);
        exp_q.push_back('{idx % W, idx / W});
    endfunction

    // Monitor: compare each window, and check outputs hold between windows
    logic [7:0] held_mat [0:4][0:4];
    logic       held_en  [0:4][0:4];
    logic [2:0] held_cx;
    logic [2:0] held_cy;
    bit         held_ok = 1'b0;

    always @(negedge clk) begin : mon
        ctr_t e;
        int   ev, ee, bad, br, bc, bact, bexp;
        if (reset) begin
            held_ok = 1'b0;
        end else if (wv) begin
            win_seen++;
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_window", int'(cx) + 8 * int'(cy), -1);
            end else begin
                e = exp_q.pop_front();
                check(int'(cx) == e.x && int'(cy) == e.y, "centre_index",
                      int'(cy) * W + int'(cx), e.y * W + e.x);
                check(int'(ptype) == ((e.y & 1) * 2 + (e.x & 1)), "centre_type",
                      int'(ptype), (e.y & 1) * 2 + (e.x & 1));
                bad = 0; br = 0; bc = 0; bact = 0; bexp = 0;
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 5; c++) begin
                        exp_entry(e.x, e.y, r, c, ev, ee);
                        if (int'(mat[r][c]) != ev || int'(en[r][c]) != ee) begin
                            if (bad == 0) begin
                                br = r; bc = c;
                                bact = int'(mat[r][c]) + 256 * int'(en[r][c]);
                                bexp = ev + 256 * ee;
                            end
                            bad++;
                        end
                    end
                end
                check(bad == 0, $sformatf("window(%0d,%0d)[%0d][%0d] val+256*en", e.x, e.y, br, bc),
                      bact, bexp);
                if (e.x == 0 && e.y == 0) begin
`ifdef BAYER_WINDOW_MIRROR_EN
                    check(mat[0][0] == 8'd18, "mirror_m00", int'(mat[0][0]), 18);
                    check(mat[0][2] == 8'd16, "mirror_m02", int'(mat[0][2]), 16);
                    bad = 0;
                    for (int r = 0; r < 5; r++)
                        for (int c = 0; c < 5; c++)
                            if (!en[r][c]) bad++;
                    check(bad == 0, "mirror_all_enabled", bad, 0);
`else
                    check(mat[2][2] == 8'd0,  "first_m22", int'(mat[2][2]), 0);
                    check(mat[2][3] == 8'd1,  "first_m23", int'(mat[2][3]), 1);
                    check(mat[3][2] == 8'd8,  "first_m32", int'(mat[3][2]), 8);
                    check(mat[4][4] == 8'd18, "first_m44", int'(mat[4][4]), 18);
                    bad = 0;
                    for (int r = 0; r < 5; r++)
                        for (int c = 0; c < 5; c++)
                            if (en[r][c] != (r >= 2 && c >= 2)) bad++;
                    check(bad == 0, "first_enables", bad, 0);
`endif
                    check(ptype == 2'b00, "first_type", int'(ptype), 0);
                end
                if (e.x == 3 && e.y == 2) begin
                    bad = 0;
                    for (int r = 0; r < 5; r++)
                        for (int c = 0; c < 5; c++)
                            if (int'(mat[r][c]) != r * 8 + c + 1 || !en[r][c]) bad++;
                    check(bad == 0, "interior_window", bad, 0);
                    check(ptype == 2'b01, "interior_type", int'(ptype), 1);
                end
`ifndef BAYER_WINDOW_MIRROR_EN
                if (e.x == 7 && e.y == 5) begin
                    bad = 0;
                    if (en[2][3]) bad++;
                    for (int r = 3; r < 5; r++)
                        for (int c = 0; c < 5; c++)
                            if (en[r][c]) bad++;
                    check(bad == 0, "last_border_enables", bad, 0);
                end
`endif
            end
            held_mat = mat;
            held_en  = en;
            held_cx  = cx;
            held_cy  = cy;
            held_ok  = 1'b1;
        end else if (held_ok) begin
            bad = 0;
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    if (mat[r][c] != held_mat[r][c] || en[r][c] != held_en[r][c]) bad++;
            if (cx != held_cx || cy != held_cy) bad++;
            check(bad == 0, "hold_stable", bad, 0);
        end
    end

    // Assert reset for three cycles, checking the reset state each cycle
    task automatic do_reset();
        int bad;
        reset = 1'b1;
        valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check(wv == 1'b0, "rst_window_valid", int'(wv), 0);
            check(ready == 1'b0, "rst_ready", int'(ready), 0);
            bad = 0;
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    if (mat[r][c] != 8'd0 || en[r][c] != 1'b0) bad++;
            check(bad == 0, "rst_matrices", bad, 0);
            check(cx == 3'd0 && cy == 3'd0 && ptype == 2'b00, "rst_centre_type",
                  int'(cx) + 8 * int'(cy) + 64 * int'(ptype), 0);
        end
        reset   = 1'b0;
        k_bench = 0;
        @(negedge clk);
        check(ready == 1'b1, "ready_after_reset", int'(ready), 1);
    endtask

    // Offer the next raster sample; called and returns on a negedge
    task automatic send(input int gap);
        int t;
        t = 0;
        pix   = 8'(k_bench);
        valid = 1'b1;
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            check(1'b0, "ready_timeout", t, 200);
            valid = 1'b0;
        end else begin
            if (k_bench >= NF) push_ctr(k_bench - NF);
            if (k_bench == W * H - 1) begin
                for (int j = W * H - NF; j < W * H; j++) push_ctr(j);
                k_bench = 0;
            end else begin
                k_bench++;
            end
            @(negedge clk);
            valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    // Count cycles with ready low after the last sample of a frame
    task automatic flush_check();
        int cnt;
        cnt = 0;
        while (!ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check(cnt == NF, "flush_ready_low_cycles", cnt, NF);
        @(negedge clk);
    endtask

    task automatic run_frame(input int gap);
        int base;
        base = win_seen;
        for (int i = 0; i < W * H - 1; i++) send(gap);
        send(0);
        flush_check();
        check(win_seen - base == W * H, "frame_window_count", win_seen - base, W * H);
    endtask

    initial begin : stim
        int base;
        reset = 1'b1;
        valid = 1'b0;
        pix   = 8'd0;
        do_reset();

        run_frame(0);
        run_frame(1);

        // Mid-frame reset after sample 30
        base = win_seen;
        for (int i = 0; i <= 30; i++) send(0);
        @(negedge clk);
        check(win_seen - base == 31 - NF, "pre_reset_windows", win_seen - base, 31 - NF);
        check(exp_q.size() == 0, "drained_before_reset", exp_q.size(), 0);
        do_reset();
        base = win_seen;
        for (int i = 0; i < NF; i++) send(0);
        @(negedge clk);
        check(win_seen == base, "no_window_before_19", win_seen - base, 0);
        send(0);
        @(negedge clk);
        check(win_seen == base + 1, "window_after_19", win_seen - base, 1);
        while (k_bench != W * H - 1) send(0);
        send(0);
        flush_check();

        repeat (5) @(negedge clk);
        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
